// File: rtl/clk_div_sched_if.sv
// Config/run-control bundle between the register block and the divider scheduler.
// No latency of its own: it only groups the wires.
// The cfg_valid/cfg_ready pair carries backpressure; en is a plain level.
// Optional cfg_err exists only when CLK_DIV_SCHED_ERR_EN is defined.
interface clk_div_sched_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             clk_out;
    logic             tick;
    logic             busy;
`ifdef CLK_DIV_SCHED_ERR_EN
    logic             cfg_err;

    modport master (output en, cfg_valid, cfg_div,
                    input  cfg_ready, clk_out, tick, busy, cfg_err);
    modport slave  (input  en, cfg_valid, cfg_div,
                    output cfg_ready, clk_out, tick, busy, cfg_err);
`else
    modport master (output en, cfg_valid, cfg_div,
                    input  cfg_ready, clk_out, tick, busy);
    modport slave  (input  en, cfg_valid, cfg_div,
                    output cfg_ready, clk_out, tick, busy);
`endif
endinterface

// File: rtl/clk_div_sched.sv
// Programmable integer clock-divider scheduler: start/stop and ratio changes land on period boundaries.
// Outputs registered; they reflect the state/count reached on the same edge (1-cycle from inputs).
// One pending ratio slot; cfg_ready drops while it is full, so the config side stalls.
// Optional feature macro: CLK_DIV_SCHED_ERR_EN (sticky cfg_err on ratios below 2).
module clk_div_sched #(
    parameter int CNT_W   = 8,
    parameter int DEF_DIV = 4
) (
    input logic            clk,
    input logic            rst,
    clk_div_sched_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);
    localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEF_DIV);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] div_cur, div_n;
    logic [CNT_W-1:0] pend_div;
    logic             pend_vld, pend_vld_n;
    logic             clk_out_r, tick_r, cfg_ready_r, busy_r;
    logic             acc, cfg_low, at_end;
    logic [CNT_W-1:0] cfg_clamped;

    assign acc         = bus.cfg_valid & ~pend_vld;
    assign cfg_low     = bus.cfg_div < MIN_DIV;
    assign cfg_clamped = cfg_low ? MIN_DIV : bus.cfg_div;
    assign at_end      = (cnt == div_cur - 1'b1);

    // Next state/count/ratio; the pending ratio is taken in IDLE or on a period boundary.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        div_n      = div_cur;
        pend_vld_n = pend_vld;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (pend_vld) begin
                    div_n      = pend_div;
                    pend_vld_n = 1'b0;
                end
                if (bus.en) begin
                    state_n = RUN;
                end
            end
            RUN, STOP: begin
                if (at_end) begin
                    cnt_n = '0;
                    if (pend_vld) begin
                        div_n      = pend_div;
                        pend_vld_n = 1'b0;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
                // A run request always wins. Without it, a period that is just
                // finishing ends the run here, so STOP never opens a fresh period.
                if (bus.en) begin
                    state_n = RUN;
                end else if (at_end) begin
                    state_n = IDLE;
                end else begin
                    state_n = STOP;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
        // Acceptance only happens with the slot empty, so it never races the apply.
        if (acc) begin
            pend_vld_n = 1'b1;
        end
    end

    // State, pending slot and registered outputs all derived from the next-state values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            div_cur     <= RST_DIV;
            pend_div    <= RST_DIV;
            pend_vld    <= 1'b0;
            clk_out_r   <= 1'b0;
            tick_r      <= 1'b0;
            cfg_ready_r <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            div_cur  <= div_n;
            pend_vld <= pend_vld_n;
            if (acc) begin
                pend_div <= cfg_clamped;
            end
            clk_out_r   <= (state_n != IDLE) && (cnt_n < (div_n >> 1));
            tick_r      <= (state_n == RUN) && (cnt_n == '0);
            cfg_ready_r <= ~pend_vld_n;
            busy_r      <= (state_n != IDLE);
        end
    end

    assign bus.clk_out   = clk_out_r;
    assign bus.tick      = tick_r;
    assign bus.cfg_ready = cfg_ready_r;
    assign bus.busy      = busy_r;

`ifdef CLK_DIV_SCHED_ERR_EN
    logic cfg_err_r;

    // Sticky flag for a sub-2 ratio request; only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_err_r <= 1'b0;
        end else if (acc && cfg_low) begin
            cfg_err_r <= 1'b1;
        end
    end

    assign bus.cfg_err = cfg_err_r;
`endif

endmodule

// File: tb/tb_clk_div_sched.sv
// Self-checking bench for clk_div_sched: directed table, corner sequences and random traffic.
// A period-level reference model predicts every registered output each cycle.
module tb_clk_div_sched;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    clk_div_sched_if #(.CNT_W(8)) bus();

    clk_div_sched #(.CNT_W(8), .DEF_DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: where we are in the current period and what comes next.
    int m_mode;      // 0 idle, 1 running, 2 finishing last period
    int m_pos;       // cycle index inside the current period
    int m_ratio;     // length of the current period
    int m_pend;      // queued ratio
    bit m_pend_vld;
    bit m_err;

    typedef struct {
        bit en;
        bit cv;
        int d;
        bit clk_o;
        bit tick;
        bit busy;
        bit rdy;
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: model condition not reached within bound", name);
    endtask

    function automatic void model_reset();
        m_mode     = 0;
        m_pos      = 0;
        m_ratio    = 4;
        m_pend     = 0;
        m_pend_vld = 0;
        m_err      = 0;
    endfunction

    task automatic model_step(input bit e, input bit v, input int d);
        bit take;
        bit period_done;
        take        = v && !m_pend_vld;
        period_done = (m_mode != 0) && (m_pos + 1 == m_ratio);
        if ((m_mode == 0 || period_done) && m_pend_vld) begin
            m_ratio    = m_pend;
            m_pend_vld = 0;
        end
        if (m_mode == 0) begin
            m_pos = 0;
            if (e) m_mode = 1;
        end else begin
            m_pos = period_done ? 0 : m_pos + 1;
            if (e) m_mode = 1;
            else if (period_done) m_mode = 0;
            else m_mode = 2;
        end
        if (take) begin
            m_pend     = (d < 2) ? 2 : d;
            m_pend_vld = 1;
            if (d < 2) m_err = 1;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_clk_out"}, bus.clk_out, (m_mode != 0) && (m_pos < m_ratio / 2));
        check({tag, "_tick"}, bus.tick, (m_mode == 1) && (m_pos == 0));
        check({tag, "_busy"}, bus.busy, m_mode != 0);
        check({tag, "_cfg_ready"}, bus.cfg_ready, !m_pend_vld);
`ifdef CLK_DIV_SCHED_ERR_EN
        check({tag, "_cfg_err"}, bus.cfg_err, m_err);
`endif
    endtask

    // Drive inputs, let one edge pass, advance the model, compare 1ns later.
    task automatic cyc(input bit e, input bit v, input int d, input string tag);
        bus.en        = e;
        bus.cfg_valid = v;
        bus.cfg_div   = 8'(d);
        @(posedge clk);
        model_step(e, v, d);
        #1;
        compare_all(tag);
    endtask

    task automatic wait_for(input int pos, input int ratio, input string name);
        bit hit;
        hit = 0;
        for (int i = 0; i < 64; i++) begin
            if (m_mode != 0 && m_pos == pos && m_ratio == ratio) begin
                hit = 1;
                break;
            end
            cyc(1, 0, 0, name);
        end
        if (!hit) timeout_fail(name);
    endtask

    task automatic drain_pending(input string name);
        for (int i = 0; i < 64 && m_pend_vld; i++) cyc(1, 0, 0, name);
        if (m_pend_vld) timeout_fail(name);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_clk_out"}, bus.clk_out, 0);
        check({tag, "_tick"}, bus.tick, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_cfg_ready"}, bus.cfg_ready, 1);
`ifdef CLK_DIV_SCHED_ERR_EN
        check({tag, "_cfg_err"}, bus.cfg_err, 0);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        int tk;

        // Directed table: default ratio 4, then a ratio-6 offer at cnt=1.
        //          en cv d  clk tick busy rdy
        tbl[0]  = '{1, 0, 0, 1, 1, 1, 1};
        tbl[1]  = '{1, 0, 0, 1, 0, 1, 1};
        tbl[2]  = '{1, 1, 6, 0, 0, 1, 0};
        tbl[3]  = '{1, 0, 0, 0, 0, 1, 0};
        tbl[4]  = '{1, 0, 0, 1, 1, 1, 1};
        tbl[5]  = '{1, 0, 0, 1, 0, 1, 1};
        tbl[6]  = '{1, 0, 0, 1, 0, 1, 1};
        tbl[7]  = '{1, 0, 0, 0, 0, 1, 1};
        tbl[8]  = '{1, 0, 0, 0, 0, 1, 1};
        tbl[9]  = '{1, 0, 0, 0, 0, 1, 1};
        tbl[10] = '{1, 0, 0, 1, 1, 1, 1};

        // 1. Reset values.
        bus.en        = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_div   = '0;
        rst           = 1'b0;
        model_reset();
        #12;
        check_reset_values("reset");
        rst = 1'b1;

        // 1/2. Default period and mid-period change.
        for (int i = 0; i < 11; i++) begin
            cyc(tbl[i].en, tbl[i].cv, tbl[i].d, $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d_exp_clk", i), bus.clk_out, tbl[i].clk_o);
            check($sformatf("tbl%0d_exp_tick", i), bus.tick, tbl[i].tick);
            check($sformatf("tbl%0d_exp_busy", i), bus.busy, tbl[i].busy);
            check($sformatf("tbl%0d_exp_rdy", i), bus.cfg_ready, tbl[i].rdy);
        end

        // 3. Offer on the boundary cycle, then a second offer while pending.
        wait_for(5, 6, "t3_wait");
        cyc(1, 1, 5, "t3_acc");
        check("t3_ready_low", bus.cfg_ready, 0);
        cyc(1, 1, 7, "t3_held");
        check("t3_still_old_ratio", m_ratio, 6);
        for (int i = 0; i < 12; i++) cyc(1, 0, 0, "t3_run");
        wait_for(0, 5, "t3_wait5");
        hi = bus.clk_out;
        for (int i = 1; i < 5; i++) begin
            cyc(1, 0, 0, "t3_n5");
            hi += bus.clk_out;
            check($sformatf("t3_n5_notick%0d", i), bus.tick, 0);
        end
        check("t3_n5_high", hi, 2);
        cyc(1, 0, 0, "t3_n5_next");
        check("t3_n5_tick", bus.tick, 1);

        // 4. Stop and restart with N=4.
        drain_pending("t4_drain");
        cyc(1, 1, 4, "t4_cfg");
        wait_for(0, 4, "t4_wait");
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, "t4_stop");
            check($sformatf("t4_stop_clk%0d", i), bus.clk_out, (i == 0) ? 1 : 0);
            check($sformatf("t4_stop_tick%0d", i), bus.tick, 0);
        end
        check("t4_idle_busy", bus.busy, 0);
        cyc(1, 0, 0, "t4_go");
        check("t4_go_tick", bus.tick, 1);
        cyc(0, 0, 0, "t4_pause");
        cyc(1, 0, 0, "t4_resume");
        check("t4_resume_notick", bus.tick, 0);
        check("t4_resume_busy", bus.busy, 1);

        // 5. Clamp of 0 and 1.
        drain_pending("t5_drain");
        cyc(1, 1, 0, "t5_zero");
`ifdef CLK_DIV_SCHED_ERR_EN
        check("t5_err_set", bus.cfg_err, 1);
`endif
        drain_pending("t5_apply0");
        cyc(1, 1, 1, "t5_one");
        drain_pending("t5_apply1");
        wait_for(0, 2, "t5_wait");
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t5_clk%0d", i), bus.clk_out, (i % 2) == 0);
            cyc(1, 0, 0, "t5_run");
        end

        // 6. Reset mid-operation with a pending ratio.
        drain_pending("t6_drain");
        cyc(1, 1, 6, "t6_cfg");
        wait_for(1, 6, "t6_wait");
        cyc(1, 1, 8, "t6_pend");
        cyc(1, 0, 0, "t6_cnt3");
        check("t6_pending", bus.cfg_ready, 0);
        #3;
        rst = 1'b0;
        #1;
        check_reset_values("t6_reset");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        cyc(1, 0, 0, "t6_start");
        tk = 0;
        for (int i = 0; i < 12; i++) begin
            check($sformatf("t6_clk%0d", i), bus.clk_out, (i % 4) < 2);
            check($sformatf("t6_tick%0d", i), bus.tick, (i % 4) == 0);
            tk += bus.tick;
            cyc(1, 0, 0, "t6_run");
        end
        check("t6_tick_count", tk, 3);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0,
                int'($urandom_range(0, 11)), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
